// File: rtl/px_rect_writer_if.sv
// Command and frame-buffer write bus of the rectangle writer. The slave modport is
// the engine side; the master modport is the command source and write-port observer.
interface px_rect_writer_if #(
  parameter int AW = 16,
  parameter int DW = 6
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [7:0]    cmd_x;
  logic [7:0]    cmd_y;
  logic [7:0]    cmd_w;
  logic [7:0]    cmd_h;
  logic [DW-1:0] cmd_color;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] mem_px_addr;
  logic [DW-1:0] mem_px_data;
  logic          px_wr;

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    output cmd_ready, busy, done, err, mem_px_addr, mem_px_data, px_wr
  );

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    input  cmd_ready, busy, done, err, mem_px_addr, mem_px_data, px_wr
  );
endinterface

// File: rtl/px_rect_writer.sv
// Frame-buffer write engine: clears the frame after reset, then fills rectangles one pixel per clock.
// Define PX_RECT_CLIP_EN to clip out-of-bounds rectangles instead of rejecting them with err.
module px_rect_writer #(
  parameter int            SCREEN_X = 184,
  parameter int            SCREEN_Y = 184,
  parameter int            AW       = 16,
  parameter int            DW       = 6,
  parameter logic [DW-1:0] BG_COLOR = '0
) (
  input  logic           clk,
  input  logic           rst,
  px_rect_writer_if.slave bus
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(SCREEN_X * SCREEN_Y - 1);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_CHECK,
    S_FILL
  } state_e;

  state_e        state_q, state_d;
  logic          px_wr_q, px_wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [7:0]    col_q, col_d;
  logic [7:0]    row_q, row_d;

  logic [7:0]    x_q, y_q, w_q, h_q;
  logic [7:0]    w_d, h_d;
  logic [DW-1:0] color_q;

  // Command-path decode
  logic          accept;
  logic          clear_last;
  logic          last_col, last_row;
  logic [8:0]    x_end, y_end;
  logic          x_oob, y_oob, zero_sz;
  logic          chk_empty, chk_reject;
  logic [7:0]    eff_w, eff_h;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] row_step_addr;

  assign accept     = (state_q == S_IDLE) && ready_q && bus.cmd_valid;
  assign clear_last = px_wr_q && (addr_q == LAST_ADDR);
  assign last_col   = (col_q == w_q - 8'd1);
  assign last_row   = (row_q == h_q - 8'd1);

  assign x_end   = {1'b0, x_q} + {1'b0, w_q};
  assign y_end   = {1'b0, y_q} + {1'b0, h_q};
  assign x_oob   = x_end > 9'(SCREEN_X);
  assign y_oob   = y_end > 9'(SCREEN_Y);
  assign zero_sz = (w_q == 8'd0) || (h_q == 8'd0);

`ifdef PX_RECT_CLIP_EN
  logic off_screen;
  assign off_screen = ({1'b0, x_q} >= 9'(SCREEN_X)) || ({1'b0, y_q} >= 9'(SCREEN_Y));
  // Clipped sizes are only consumed when the origin is on screen, so the subtraction stays positive.
  assign eff_w      = x_oob ? 8'(SCREEN_X - int'(x_q)) : w_q;
  assign eff_h      = y_oob ? 8'(SCREEN_Y - int'(y_q)) : h_q;
  assign chk_empty  = zero_sz || off_screen;
  assign chk_reject = 1'b0;
`else
  assign eff_w      = w_q;
  assign eff_h      = h_q;
  assign chk_empty  = zero_sz;
  assign chk_reject = x_oob || y_oob;
`endif

  // Constant multiply by the frame width, evaluated once per rectangle.
  assign start_addr    = AW'(y_q) * AW'(SCREEN_X) + AW'(x_q);
  assign row_step_addr = addr_q + AW'(SCREEN_X) - AW'(w_q) + AW'(1);

  // State and output registers.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CLEAR;
      px_wr_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      w_q     <= '0;
      h_q     <= '0;
    end else begin
      state_q <= state_d;
      px_wr_q <= px_wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      col_q   <= col_d;
      row_q   <= row_d;
      w_q     <= w_d;
      h_q     <= h_d;
    end
  end

  // NOTE: origin and colour are only read after an accept loads them, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      x_q     <= bus.cmd_x;
      y_q     <= bus.cmd_y;
      color_q <= bus.cmd_color;
    end
  end

  // Next-state and loop counters
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    w_d     = w_q;
    h_d     = h_q;
    unique case (state_q)
      S_CLEAR: if (clear_last) state_d = S_IDLE;
      S_IDLE: begin
        if (accept) begin
          state_d = S_CHECK;
          w_d     = bus.cmd_w;
          h_d     = bus.cmd_h;
        end
      end
      S_CHECK: begin
        if (chk_empty || chk_reject) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_FILL;
          w_d     = eff_w;
          h_d     = eff_h;
          col_d   = '0;
          row_d   = '0;
        end
      end
      S_FILL: begin
        if (last_col) begin
          col_d = '0;
          row_d = row_q + 8'd1;
          if (last_row) state_d = S_IDLE;
        end else begin
          col_d = col_q + 8'd1;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // Registered outputs, decided one cycle ahead from the state being entered
  always_comb begin
    px_wr_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    unique case (state_q)
      S_CLEAR: begin
        if (!clear_last) begin
          px_wr_d = 1'b1;
          addr_d  = px_wr_q ? addr_q + AW'(1) : '0;
          data_d  = BG_COLOR;
        end
      end
      S_CHECK: begin
        if (chk_empty) begin
          done_d = 1'b1;
        end else if (chk_reject) begin
          err_d = 1'b1;
        end else begin
          px_wr_d = 1'b1;
          addr_d  = start_addr;
          data_d  = color_q;
        end
      end
      S_FILL: begin
        if (last_col && last_row) begin
          done_d = 1'b1;
        end else begin
          px_wr_d = 1'b1;
          addr_d  = last_col ? row_step_addr : addr_q + AW'(1);
          data_d  = color_q;
        end
      end
      default: ;
    endcase
  end

  assign bus.cmd_ready   = ready_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.px_wr       = px_wr_q;
  assign bus.mem_px_addr = addr_q;
  assign bus.mem_px_data = data_q;

endmodule

// File: tb/tb_px_rect_writer.sv
// Directed bench for px_rect_writer: frame clear, fills, empty/out-of-bounds commands,
// back-to-back command handshake and reset abort. Build with PX_RECT_CLIP_EN for the clipping variant.
module tb_px_rect_writer;

  localparam int NPIX = 184 * 184;

  logic clk;
  logic rst;

  px_rect_writer_if #(.AW(16), .DW(6)) bus ();

  px_rect_writer #(
    .SCREEN_X(184), .SCREEN_Y(184), .AW(16), .DW(6), .BG_COLOR(6'b000000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;
  int both_cnt = 0;

  logic [15:0] wr_a[$];
  logic [5:0]  wr_d[$];
  int          exp_a[8];
  int          first_wr, done_cyc, err_cyc;
  logic        ready_at_end;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue a command from an IDLE negedge; returns at the negedge of the CHECK cycle.
  task automatic send(input logic [7:0] x, y, w, h, input logic [5:0] c, input string tag);
    bus.cmd_x = x; bus.cmd_y = y; bus.cmd_w = w; bus.cmd_h = h; bus.cmd_color = c;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check($sformatf("%s_check_ready", tag), 32'(bus.cmd_ready), 32'd0);
    check($sformatf("%s_check_nowr", tag), 32'(bus.px_wr), 32'd0);
  endtask

  // Collect writes cycle by cycle until done/err or the cycle budget runs out.
  task automatic collect(input int max_cyc, input string tag);
    bit fin = 0;
    wr_a.delete(); wr_d.delete();
    first_wr = -1; done_cyc = -1; err_cyc = -1; ready_at_end = 1'b0;
    for (int c = 0; c < max_cyc && !fin; c++) begin
      @(negedge clk);
      if (bus.px_wr) begin
        if (first_wr < 0) first_wr = c;
        wr_a.push_back(bus.mem_px_addr);
        wr_d.push_back(bus.mem_px_data);
      end
      if (bus.done && bus.err) both_cnt++;
      if (bus.done) done_cyc = c;
      if (bus.err) err_cyc = c;
      if (bus.done || bus.err) begin
        ready_at_end = bus.cmd_ready;
        fin = 1;
      end
    end
    check($sformatf("%s_terminated", tag), 32'(fin), 32'd1);
  endtask

  task automatic check_writes(input string tag, input int n, input logic [5:0] color);
    check($sformatf("%s_count", tag), 32'(wr_a.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < wr_a.size()) begin
        check($sformatf("%s_addr%0d", tag, i), 32'(wr_a[i]), 32'(exp_a[i]));
        check($sformatf("%s_data%0d", tag, i), 32'(wr_d[i]), 32'(color));
      end
    end
  endtask

  // Walk a full-frame clear starting at the current negedge; counts cycles that deviate.
  task automatic check_clear(input string tag);
    int bad = 0;
    for (int i = 0; i < NPIX; i++) begin
      @(negedge clk);
      if (!(bus.px_wr === 1'b1 && bus.mem_px_addr === 16'(i) && bus.mem_px_data === 6'd0
            && bus.done === 1'b0 && bus.err === 1'b0 && bus.busy === 1'b1))
        bad++;
    end
    check($sformatf("%s_bad_cycles", tag), 32'(bad), 32'd0);
    @(negedge clk);
    check($sformatf("%s_end_wr", tag), 32'(bus.px_wr), 32'd0);
    check($sformatf("%s_end_ready", tag), 32'(bus.cmd_ready), 32'd1);
    check($sformatf("%s_end_busy", tag), 32'(bus.busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_x = '0; bus.cmd_y = '0; bus.cmd_w = '0; bus.cmd_h = '0; bus.cmd_color = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_px_wr", 32'(bus.px_wr), 32'd0);
    check("rst_addr", 32'(bus.mem_px_addr), 32'd0);
    check("rst_data", 32'(bus.mem_px_data), 32'd0);
    check("rst_ready", 32'(bus.cmd_ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd1);
    check("rst_done_err", 32'({bus.done, bus.err}), 32'd0);

    // Post-reset clear: first write in the first cycle after release
    rst = 1'b0;
    check_clear("clear1");

    // Basic fill 2x3 at (10,20)
    send(8'd10, 8'd20, 8'd2, 8'd3, 6'b110000, "fill1");
    collect(50, "fill1");
    exp_a = '{3690, 3691, 3874, 3875, 4058, 4059, 0, 0};
    check_writes("fill1", 6, 6'b110000);
    check("fill1_first_wr", 32'(first_wr), 32'd0);
    check("fill1_done_cyc", 32'(done_cyc), 32'd6);
    check("fill1_err_cyc", 32'(err_cyc), 32'hFFFF_FFFF);
    check("fill1_ready_at_done", 32'(ready_at_end), 32'd1);
    @(negedge clk);
    check("fill1_done_1cyc", 32'(bus.done), 32'd0);

    // Zero width: done right after CHECK, no writes
    send(8'd3, 8'd4, 8'd0, 8'd5, 6'b101010, "zero");
    collect(10, "zero");
    check("zero_count", 32'(wr_a.size()), 32'd0);
    check("zero_done_cyc", 32'(done_cyc), 32'd0);
    @(negedge clk);
    check("zero_idle_ready", 32'(bus.cmd_ready), 32'd1);
    check("zero_idle_busy", 32'(bus.busy), 32'd0);

    // Right-edge overflow
    send(8'd180, 8'd0, 8'd10, 8'd1, 6'b000011, "oob");
    collect(30, "oob");
`ifdef PX_RECT_CLIP_EN
    exp_a = '{180, 181, 182, 183, 0, 0, 0, 0};
    check_writes("oob_clip", 4, 6'b000011);
    check("oob_clip_done_cyc", 32'(done_cyc), 32'd4);
    check("oob_clip_err_cyc", 32'(err_cyc), 32'hFFFF_FFFF);
`else
    check("oob_count", 32'(wr_a.size()), 32'd0);
    check("oob_err_cyc", 32'(err_cyc), 32'd0);
    check("oob_done_cyc", 32'(done_cyc), 32'hFFFF_FFFF);
`endif
    @(negedge clk);
    check("oob_pulse_1cyc", 32'({bus.done, bus.err}), 32'd0);

    // cmd_valid held high across two commands
    bus.cmd_x = 8'd0; bus.cmd_y = 8'd0; bus.cmd_w = 8'd3; bus.cmd_h = 8'd1; bus.cmd_color = 6'd1;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_x = 8'd5; bus.cmd_y = 8'd1; bus.cmd_w = 8'd2; bus.cmd_h = 8'd2; bus.cmd_color = 6'd2;
    collect(20, "qa");
    exp_a = '{0, 1, 2, 0, 0, 0, 0, 0};
    check_writes("qa", 3, 6'd1);
    check("qa_done_cyc", 32'(done_cyc), 32'd3);
    check("qa_ready_at_done", 32'(ready_at_end), 32'd1);
    @(negedge clk);
    check("qb_accepted_ready", 32'(bus.cmd_ready), 32'd0);
    check("qb_accepted_busy", 32'(bus.busy), 32'd1);
    check("qb_check_nowr", 32'(bus.px_wr), 32'd0);
    bus.cmd_valid = 1'b0;
    collect(20, "qb");
    exp_a = '{189, 190, 373, 374, 0, 0, 0, 0};
    check_writes("qb", 4, 6'd2);
    check("qb_first_wr", 32'(first_wr), 32'd0);
    check("qb_done_cyc", 32'(done_cyc), 32'd4);

    // Reset during the third write of a 4x4 fill at (0,2)
    send(8'd0, 8'd2, 8'd4, 8'd4, 6'b000111, "abort");
    repeat (3) @(negedge clk);
    check("abort_3rd_wr", 32'(bus.px_wr), 32'd1);
    check("abort_3rd_addr", 32'(bus.mem_px_addr), 32'd370);
    rst = 1'b1;
    @(negedge clk);
    check("abort_rst_wr", 32'(bus.px_wr), 32'd0);
    check("abort_rst_addr", 32'(bus.mem_px_addr), 32'd0);
    check("abort_rst_busy", 32'(bus.busy), 32'd1);
    check("abort_rst_done_err", 32'({bus.done, bus.err}), 32'd0);
    rst = 1'b0;
    check_clear("clear2");

    check("done_err_exclusive", 32'(both_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
